sram_l1_banked_wrap: RTL

//  Parametrised successor to the single-bank L1 SRAM wrapper. It holds NUM_BANKS address-interleaved SRAM banks.
//  A ready/valid request port replaces the csb/we strobe protocol.

---
 rtl/sram_l1_banked_wrap.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sram_l1_banked_wrap.sv
// Banked L1 SRAM wrapper: address-interleaved banks behind a ready/valid port,
// per-word valid bits cleared by reset/flush, fixed-latency in-order read pipeline.

module sram_l1_banked_wrap_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = DATA_WIDTH/8,
  parameter int ROW_W      = 8,
  parameter int BANK_CYCLE = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_acc,
  input  logic                  i_we,
  input  logic [ROW_W-1:0]      i_row,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [NUM_WMASKS-1:0] i_wmask,
  input  logic                  i_flush,
  output logic                  o_idle,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rhit
);
  localparam int ROWS = 2**ROW_W;
  localparam int CW   = $clog2(BANK_CYCLE) + 1;

  logic [CW-1:0]         r_busy;
  logic [ROWS-1:0]       r_vld;
  logic [DATA_WIDTH-1:0] r_mem [ROWS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else if (i_acc) begin
      r_busy <= CW'(BANK_CYCLE - 1);
    end else if (r_busy != '0) begin
      r_busy <= r_busy - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else if (i_acc && i_we) begin
      r_vld[i_row] <= 1'b1;
    end
  end

  // Storage contents are never reset; the valid bit masks stale words.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (i_acc && i_we && i_wmask[i]) r_mem[i_row][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_idle  = (r_busy == '0);
  assign o_rdata = r_mem[i_row];
  assign o_rhit  = r_vld[i_row];
endmodule

module sram_l1_banked_wrap #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int NUM_WMASKS   = DATA_WIDTH/8,
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 3,
  parameter int BANK_CYCLE   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [NUM_WMASKS-1:0] i_req_wmask,
  input  logic                  i_flush,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_hit
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BB        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;

  logic [BB-1:0]                         w_bank;
  logic [ROW_W-1:0]                      w_row;
  logic [NUM_BANKS-1:0]                  w_idle;
  logic [NUM_BANKS-1:0]                  w_bk_hit;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  w_bk_data;
  logic                                  w_acc;
  logic                                  w_rd_acc;
  logic [DATA_WIDTH-1:0]                 w_sdata;

  logic [READ_LATENCY:0]                 r_vld_pipe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_dat_pipe;
  logic [READ_LATENCY-1:0]               r_hit_pipe;
  logic [DATA_WIDTH-1:0]                 r_rsp_data;
  logic                                  r_rsp_hit;

  generate
    if (NUM_BANKS > 1) begin : g_bsel
      assign w_bank = i_req_addr[BANK_BITS-1:0];
    end else begin : g_bsel1
      assign w_bank = '0;
    end
  endgenerate
  assign w_row = i_req_addr[ADDR_WIDTH-1:BANK_BITS];

  assign o_req_ready = !i_flush && w_idle[w_bank];
  assign w_acc       = i_req_valid && o_req_ready;
  assign w_rd_acc    = w_acc && !i_req_we;
  assign w_sdata     = w_bk_hit[w_bank] ? w_bk_data[w_bank] : '0;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sram_l1_banked_wrap_bank #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS),
        .ROW_W(ROW_W), .BANK_CYCLE(BANK_CYCLE)
      ) u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_acc   (w_acc && (w_bank == BB'(b))),
        .i_we    (i_req_we),
        .i_row   (w_row),
        .i_wdata (i_req_wdata),
        .i_wmask (i_req_wmask),
        .i_flush (i_flush),
        .o_idle  (w_idle[b]),
        .o_rdata (w_bk_data[b]),
        .o_rhit  (w_bk_hit[b])
      );
    end
  endgenerate

  // Stage 0 captures at the accept edge; the top bit is the response strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
      r_hit_pipe <= '0;
      r_rsp_data <= '0;
      r_rsp_hit  <= 1'b0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[READ_LATENCY-1:0], w_rd_acc};
      r_dat_pipe[0] <= w_sdata;
      r_hit_pipe[0] <= w_bk_hit[w_bank];
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_dat_pipe[k] <= r_dat_pipe[k-1];
        r_hit_pipe[k] <= r_hit_pipe[k-1];
      end
      if (r_vld_pipe[READ_LATENCY-1]) begin
        r_rsp_data <= r_dat_pipe[READ_LATENCY-1];
        r_rsp_hit  <= r_hit_pipe[READ_LATENCY-1];
      end
    end
  end

  assign o_rsp_valid = r_vld_pipe[READ_LATENCY];
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_hit   = r_rsp_hit;
endmodule
